// File: rtl/hs_listener.sv
// Receiving side of a 4-phase req/ack handshake: synchronizes req_in, captures the bundled word,
// offers it on valid/ready, then acknowledges. Define HS_LISTENER_STATS_EN to build xfer_count.
module hs_listener #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk1,
    input  logic                  reset1,
    input  logic                  req_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ack_out,
    output logic                  rcv_valid,
    output logic [DATA_WIDTH-1:0] rcv_data,
    input  logic                  rcv_ready,
    output logic                  busy,
    output logic                  proto_err,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   req_prev_q;
    state_t                 state_q;
    logic                   ack_q;
    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   err_q;

    always_ff @(posedge clk1 or negedge reset1) begin
        if (!reset1) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_sync = sync_q[SYNC_STAGES-1];

    // req_prev_q lets HOLD distinguish the falling edge of req_sync from a level
    // that has already been reported, so proto_err is a single-cycle pulse.
    always_ff @(posedge clk1 or negedge reset1) begin
        if (!reset1) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_sync;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_sync) begin
                        data_q  <= data_in;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (req_prev_q && !req_sync) begin
                        err_q <= 1'b1;
                    end
                    if (valid_q && rcv_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!req_sync) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_out   = ack_q;
    assign rcv_valid = valid_q;
    assign rcv_data  = data_q;
    assign proto_err = err_q;
    assign busy      = (state_q != IDLE);

`ifdef HS_LISTENER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Counts on the ACK->IDLE edge, i.e. once per completed return-to-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ACK && !req_sync) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk1 or negedge reset1) begin
        if (!reset1) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_hs_listener.sv
// Directed bench for hs_listener; a second instance with a 2-bit counter covers wrap-around.
module tb_hs_listener;

    logic        clk1 = 1'b0;
    logic        reset1;
    logic        req_in;
    logic [7:0]  data_in;
    logic        rcv_ready;
    logic        ack_out;
    logic        rcv_valid;
    logic [7:0]  rcv_data;
    logic        busy;
    logic        proto_err;
    logic [15:0] xfer_count;

    logic        w_ack_out;
    logic        w_rcv_valid;
    logic [7:0]  w_rcv_data;
    logic        w_busy;
    logic        w_proto_err;
    logic [1:0]  w_xfer_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];

`ifdef HS_LISTENER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk1 = ~clk1;

    hs_listener #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(16)) dut (
        .clk1(clk1), .reset1(reset1), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .rcv_valid(rcv_valid), .rcv_data(rcv_data),
        .rcv_ready(rcv_ready), .busy(busy), .proto_err(proto_err),
        .xfer_count(xfer_count)
    );

    hs_listener #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut_w (
        .clk1(clk1), .reset1(reset1), .req_in(req_in), .data_in(data_in),
        .ack_out(w_ack_out), .rcv_valid(w_rcv_valid), .rcv_data(w_rcv_data),
        .rcv_ready(rcv_ready), .busy(w_busy), .proto_err(w_proto_err),
        .xfer_count(w_xfer_count)
    );

    // Record every word the consumer accepts (valid & ready are stable mid-cycle).
    always @(negedge clk1) begin
        if (reset1 === 1'b1 && rcv_valid === 1'b1 && rcv_ready === 1'b1) begin
            got_q.push_back(rcv_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
        $display("check %-16s got 0x%0h exp 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        reset1 = 1'b0;
        step();
        step();
        reset1 = 1'b1;
        step();
    endtask

    // Full handshake with rcv_ready high; every wait is bounded.
    task automatic xfer(input logic [7:0] d);
        int n;
        data_in = d;
        req_in  = 1'b1;
        n = 0;
        while (ack_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ack_out !== 1'b1) check("ack_rise_tmo", 32'(ack_out), 32'd1);
        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        if (ack_out !== 1'b0) check("ack_fall_tmo", 32'(ack_out), 32'd0);
    endtask

    initial begin
        int pulses;
        reset1    = 1'b0;
        req_in    = 1'b0;
        data_in   = 8'h00;
        rcv_ready = 1'b1;
        step();
        step();
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_valid", 32'(rcv_valid), 32'd0);
        check("rst_data", 32'(rcv_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        check("rst_count", 32'(xfer_count), 32'd0);
        reset1 = 1'b1;
        step();

        // Basic transfer: edge E is the first step below.
        data_in = 8'hA5;
        req_in  = 1'b1;
        step();
        step();
        check("b_valid_e1", 32'(rcv_valid), 32'd0);
        step();
        check("b_valid_e2", 32'(rcv_valid), 32'd1);
        check("b_data_e2", 32'(rcv_data), 32'hA5);
        check("b_ack_e2", 32'(ack_out), 32'd0);
        check("b_busy_e2", 32'(busy), 32'd1);
        step();
        check("b_ack_e3", 32'(ack_out), 32'd1);
        check("b_valid_e3", 32'(rcv_valid), 32'd0);
        req_in = 1'b0;
        step();
        step();
        check("b_ack_f1", 32'(ack_out), 32'd1);
        step();
        check("b_ack_f2", 32'(ack_out), 32'd0);
        check("b_busy_f2", 32'(busy), 32'd0);

        // Back-pressure for 10 cycles.
        rcv_ready = 1'b0;
        data_in   = 8'h3C;
        req_in    = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(rcv_valid), 32'd1);
            check("bp_data", 32'(rcv_data), 32'h3C);
            check("bp_ack", 32'(ack_out), 32'd0);
            step();
        end
        rcv_ready = 1'b1;
        step();
        check("bp_valid_acc", 32'(rcv_valid), 32'd0);
        check("bp_ack_acc", 32'(ack_out), 32'd1);
        req_in = 1'b0;
        xfer_wait_idle();

        // Back-to-back four words from a clean counter.
        do_reset();
        got_q.delete();
        for (int i = 1; i <= 4; i++) xfer(8'(i));
        check("b2b_n", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("b2b_word", 32'(got_q[i]), 32'(i + 1));
        check("b2b_count", 32'(xfer_count), STATS ? 32'd4 : 32'd0);
        check("b2b_count_w", 32'(w_xfer_count), 32'd0);

        // Protocol violation: req dropped while HOLD waits for the consumer.
        got_q.delete();
        rcv_ready = 1'b0;
        data_in   = 8'h5A;
        req_in    = 1'b1;
        step();
        step();
        step();
        check("pv_valid", 32'(rcv_valid), 32'd1);
        req_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (proto_err === 1'b1) pulses++;
            check("pv_hold_ack", 32'(ack_out), 32'd0);
        end
        check("pv_pulses", 32'(pulses), 32'd1);
        rcv_ready = 1'b1;
        step();
        check("pv_ack1", 32'(ack_out), 32'd1);
        step();
        check("pv_ack2", 32'(ack_out), 32'd0);
        check("pv_busy", 32'(busy), 32'd0);
        check("pv_words", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("pv_word", 32'(got_q[0]), 32'h5A);
        check("pv_count", 32'(xfer_count), STATS ? 32'd5 : 32'd0);

        // Reset asserted mid-HOLD takes effect between clock edges.
        rcv_ready = 1'b0;
        data_in   = 8'h77;
        req_in    = 1'b1;
        step();
        step();
        step();
        check("rm_busy_pre", 32'(busy), 32'd1);
        #2;
        reset1 = 1'b0;
        req_in = 1'b0;
        #1;
        check("rm_valid", 32'(rcv_valid), 32'd0);
        check("rm_ack", 32'(ack_out), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        step();
        step();
        reset1 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("rm_idle_busy", 32'(busy), 32'd0);
        check("rm_idle_valid", 32'(rcv_valid), 32'd0);
        check("rm_count", 32'(xfer_count), 32'd0);

        // Counter wrap on the 2-bit instance.
        rcv_ready = 1'b1;
        for (int i = 0; i < 5; i++) xfer(8'(8'h10 + i));
        check("wrap_count_w", 32'(w_xfer_count), STATS ? 32'd1 : 32'd0);
        check("wrap_count", 32'(xfer_count), STATS ? 32'd5 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic xfer_wait_idle();
        int n;
        n = 0;
        while (ack_out !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check("idle_ack", 32'(ack_out), 32'd0);
    endtask

endmodule
